// File: rtl/regfile_write_scheduler_pkg.sv
// rtl/regfile_write_scheduler_pkg.sv - shared types and constants for the register file write scheduler
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// rtl/regfile_write_scheduler_if.sv - producer, register file and status bundle (REGFILE_WRITE_FORWARD_EN adds the lookup port)
interface regfile_write_scheduler_if #(
    parameter int CNT_W = 3
) ();
    logic             alu_valid;
    logic             alu_ready;
    logic [4:0]       alu_reg;
    logic [31:0]      alu_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [4:0]       mem_reg;
    logic [31:0]      mem_data;
    logic [4:0]       rf_write_reg;
    logic [31:0]      rf_write_data;
    logic             rf_reg_write;
    logic [CNT_W-1:0] count;
    logic             empty;
`ifdef REGFILE_WRITE_FORWARD_EN
    logic [4:0]       fwd_reg;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
`endif

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready, rf_write_reg, rf_write_data, rf_reg_write, count, empty
`ifdef REGFILE_WRITE_FORWARD_EN
        , output fwd_reg
        , input  fwd_hit, fwd_data
`endif
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready, rf_write_reg, rf_write_data, rf_reg_write, count, empty
`ifdef REGFILE_WRITE_FORWARD_EN
        , input  fwd_reg
        , output fwd_hit, fwd_data
`endif
    );

endinterface

// File: rtl/regfile_write_scheduler_wb_fifo.sv
// rtl/regfile_write_scheduler_wb_fifo.sv - dual-push single-pop writeback FIFO (REGFILE_WRITE_FORWARD_EN exposes entries by age)
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_a,
    input  wb_entry_t        entry_a,
    input  logic             push_b,
    input  wb_entry_t        entry_b,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count
`ifdef REGFILE_WRITE_FORWARD_EN
    , output wb_entry_t      by_age [DEPTH]
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_b;
    logic [1:0]       n_push;
    logic             do_pop;

    assign n_push   = {1'b0, push_a} + {1'b0, push_b};
    assign do_pop   = pop && (count != '0);
    // When both push, entry_b lands one slot behind entry_a.
    assign wr_ptr_b = push_a ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_a) mem[wr_ptr]   <= entry_a;
        if (push_b) mem[wr_ptr_b] <= entry_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            count  <= count + CNT_W'(n_push) - CNT_W'(do_pop);
        end
    end

`ifdef REGFILE_WRITE_FORWARD_EN
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            by_age[i] = mem[rd_ptr + PTR_W'(i)];
        end
    end
`endif

endmodule

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - merges ALU and load writebacks onto the single register file write port (REGFILE_WRITE_FORWARD_EN)
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    regfile_write_scheduler_if.slave bus
);
    wb_entry_t        head;
    wb_entry_t        entry_a;
    wb_entry_t        entry_b;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] free;
    logic             alu_push;
    logic             mem_push;
    logic             drain;
`ifdef REGFILE_WRITE_FORWARD_EN
    wb_entry_t        by_age [DEPTH];
`endif

    // Free space ignores this cycle's pop, so a full queue never accepts.
    assign free = CNT_W'(DEPTH) - fifo_count;

    assign bus.alu_ready = !reset && (free != '0);
    assign bus.mem_ready = !reset && ((free >= CNT_W'(2)) ||
                                      ((free == CNT_W'(1)) && !bus.alu_valid));

    // Register 0 results complete the handshake but are dropped.
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_reg != ZERO_REG);
    assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_reg != ZERO_REG);

    assign entry_a = '{reg_addr: bus.alu_reg, data: bus.alu_data};
    assign entry_b = '{reg_addr: bus.mem_reg, data: bus.mem_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_a  (alu_push),
        .entry_a (entry_a),
        .push_b  (mem_push),
        .entry_b (entry_b),
        .pop     (drain),
        .head    (head),
        .count   (fifo_count)
`ifdef REGFILE_WRITE_FORWARD_EN
        , .by_age (by_age)
`endif
    );

    // Head is written and popped at the same edge; suppressed under reset.
    assign drain             = !reset && (fifo_count != '0);
    assign bus.rf_reg_write  = drain;
    assign bus.rf_write_reg  = drain ? head.reg_addr : '0;
    assign bus.rf_write_data = drain ? head.data : '0;
    assign bus.count         = fifo_count;
    assign bus.empty         = (fifo_count == '0);

`ifdef REGFILE_WRITE_FORWARD_EN
    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < fifo_count) && (bus.fwd_reg != ZERO_REG) &&
                (by_age[i].reg_addr == bus.fwd_reg)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = by_age[i].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - scoreboard bench for regfile_write_scheduler (REGFILE_WRITE_FORWARD_EN checks the lookup)
module tb_regfile_write_scheduler;
    import regfile_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    wb_entry_t  sb_q[$];
    logic [4:0] fwd_sel = 5'd0;

    regfile_write_scheduler_if #(.CNT_W(CNT_W)) bus ();

    regfile_write_scheduler #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

`ifdef REGFILE_WRITE_FORWARD_EN
    assign bus.fwd_reg = fwd_sel;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the write port must present exactly the scoreboard head each cycle.
    always @(negedge clk) begin
        wb_entry_t e;
        if (rst) begin
            check("reset_rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
            check("reset_alu_ready", 32'(bus.alu_ready), 32'd0);
            check("reset_mem_ready", 32'(bus.mem_ready), 32'd0);
        end else begin
            check("count", 32'(bus.count), 32'(sb_q.size()));
            check("empty", 32'(bus.empty), 32'(sb_q.size() == 0));
`ifdef REGFILE_WRITE_FORWARD_EN
            begin
                logic        hit  = 1'b0;
                logic [31:0] data = 32'd0;
                foreach (sb_q[i]) begin
                    if (fwd_sel != 5'd0 && sb_q[i].reg_addr == fwd_sel) begin
                        hit  = 1'b1;
                        data = sb_q[i].data;
                    end
                end
                check("fwd_hit", 32'(bus.fwd_hit), 32'(hit));
                check("fwd_data", bus.fwd_data, data);
            end
`endif
            if (sb_q.size() == 0) begin
                check("idle_rf_reg_write", 32'(bus.rf_reg_write), 32'd0);
                check("idle_rf_write_reg", 32'(bus.rf_write_reg), 32'd0);
                check("idle_rf_write_data", bus.rf_write_data, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rf_reg_write", 32'(bus.rf_reg_write), 32'd1);
                check("rf_write_reg", 32'(bus.rf_write_reg), 32'(e.reg_addr));
                check("rf_write_data", bus.rf_write_data, e.data);
            end
        end
    end

    // One cycle of stimulus; the model decides acceptance from free space alone.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         output logic a_x, output logic m_x);
        int  free;
        logic a_rdy, m_rdy;
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
        #1;
        free  = DEPTH - sb_q.size();
        a_rdy = !rst && free >= 1;
        m_rdy = !rst && (free >= 2 || (free == 1 && !av));
        check("alu_ready", 32'(bus.alu_ready), 32'(a_rdy));
        check("mem_ready", 32'(bus.mem_ready), 32'(m_rdy));
        a_x = av && a_rdy;
        m_x = mv && m_rdy;
        @(posedge clk);
        if (rst) sb_q.delete();
        else begin
            if (a_x && ar != 5'd0) sb_q.push_back('{reg_addr: ar, data: ad});
            if (m_x && mr != 5'd0) sb_q.push_back('{reg_addr: mr, data: md});
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic a_x, m_x;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a_x, m_x);
    endtask

    initial begin
        logic a_x, m_x;
        logic [31:0] ad, md;
        logic [4:0]  ar, mr;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, a_x, m_x);
        idle(3);

        cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, a_x, m_x);
        idle(3);

        ad = 32'h100; md = 32'h200;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 5'd9, ad, 1'b1, 5'd10, md, a_x, m_x);
            if (a_x) ad++;
            if (m_x) md++;
        end
        idle(6);

        cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, a_x, m_x);
        check("reg0_transfer", 32'(a_x), 32'd1);
        idle(2);

        cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, a_x, m_x);
        cycle(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, a_x, m_x);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);

        fwd_sel = 5'd7;
        cycle(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, a_x, m_x);
        idle(1);
        fwd_sel = 5'd0;
        cycle(1'b1, 5'd7, 32'hC, 1'b1, 5'd0, 32'hD, a_x, m_x);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            ar = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
            mr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
            fwd_sel = 5'($urandom_range(0, 8));
            rst = ($urandom_range(0, 59) == 0);
            cycle(1'($urandom_range(0, 2) != 0), ar, $urandom,
                  1'($urandom_range(0, 2) != 0), mr, $urandom, a_x, m_x);
            rst = 1'b0;
        end
        idle(DEPTH + 2);
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
